// File: rtl/shift_sequencer.sv
// shift_sequencer: W-bit shift/rotate register with a CW-bit step counter and
// an IDLE/RUN/DONE controller. A full run takes 2^CW steps, followed by a
// one-cycle done pulse.
// Optional feature macro: SHSEQ_EARLY_STOP_EN -- end the run early on the step
// that leaves y all zeros (wrap termination still applies).
module shift_sequencer #(
  parameter int W  = 8,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  x,
  input  logic [1:0]    on,
  input  logic          start,
  output logic [W-1:0]  y,
  output logic [CW-1:0] s,
  output logic          b,
  output logic [1:0]    regime,
  output logic          active,
  output logic          done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_SHL = 2'b01;
  localparam logic [1:0] MODE_ROR = 2'b10;
  localparam logic [1:0] MODE_ASR = 2'b11;

  state_t        state_r;
  logic [W-1:0]  step_y_s;
  logic          step_b_s;
  logic [CW-1:0] step_s_s;
  logic          finish_s;

  // Next register value and carry-out bit for one step in the latched mode.
  always_comb begin
    step_y_s = y;
    step_b_s = b;
    case (regime)
      MODE_SHL: begin
        step_b_s = y[W-1];
        step_y_s = {y[W-2:0], 1'b0};
      end
      MODE_ROR: begin
        step_b_s = y[0];
        step_y_s = {y[0], y[W-1:1]};
      end
      MODE_ASR: begin
        step_b_s = y[0];
        step_y_s = {y[W-1], y[W-1:1]};
      end
      default: begin
        step_y_s = y;
        step_b_s = b;
      end
    endcase
  end

  // Step count after this step and whether this step ends the run.
  always_comb begin
    step_s_s = s + CW'(1);
`ifdef SHSEQ_EARLY_STOP_EN
    finish_s = (step_s_s == {CW{1'b0}}) || (step_y_s == {W{1'b0}});
`else
    finish_s = (step_s_s == {CW{1'b0}});
`endif
  end

  // Controller and datapath registers: accept in IDLE, step in RUN, pulse in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      y       <= {W{1'b0}};
      s       <= {CW{1'b0}};
      b       <= 1'b0;
      regime  <= 2'b00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && (on != 2'b00)) begin
            y       <= x;
            s       <= {CW{1'b0}};
            b       <= 1'b0;
            regime  <= on;
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          y <= step_y_s;
          b <= step_b_s;
          s <= step_s_s;
          if (finish_s) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Status flags are decoded straight from the state register.
  assign active = (state_r == ST_RUN);
  assign done   = (state_r == ST_DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer (W=8, CW=3): a behavioural model feeds
// an expected-output queue each cycle; a table of runs checks known waveform points.
module tb_shift_sequencer;

  localparam int W  = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  x;
  logic [1:0]    on;
  logic          start;
  logic [W-1:0]  y;
  logic [CW-1:0] s;
  logic          b;
  logic [1:0]    regime;
  logic          active;
  logic          done;

  shift_sequencer #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .x(x), .on(on), .start(start),
    .y(y), .s(s), .b(b), .regime(regime), .active(active), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  y;
    logic [CW-1:0] s;
    logic          b;
    logic [1:0]    regime;
    logic          active;
    logic          done;
  } obs_t;

  typedef struct {
    logic [1:0]    mode;
    logic [W-1:0]  x;
    logic [W-1:0]  y1;
    logic          b1;
    logic [W-1:0]  y_end;
    logic          b_end;
    logic [CW-1:0] s_end;
    int            end_edge;
  } vec_t;

  typedef enum {M_IDLE, M_RUN, M_DONE} mst_t;

  obs_t exp_q[$];
  int n_total = 0;
  int n_pass  = 0;

  mst_t          m_st;
  logic [W-1:0]  m_y;
  logic [CW-1:0] m_s;
  logic          m_b;
  logic [1:0]    m_reg;

  vec_t tv[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_y = '0; m_s = '0; m_b = 1'b0; m_reg = 2'b00;
    exp_q.delete();
  endtask

  task automatic model_edge(input logic st, input logic [1:0] o, input logic [W-1:0] xv);
    logic [W-1:0] ny;
    logic nb;
    case (m_st)
      M_IDLE: if (st && o != 2'b00) begin
        m_y = xv; m_s = '0; m_b = 1'b0; m_reg = o; m_st = M_RUN;
      end
      M_RUN: begin
        case (m_reg)
          2'b01:   begin nb = m_y[W-1]; ny = m_y << 1; end
          2'b10:   begin nb = m_y[0];   ny = (m_y >> 1) | (m_y << (W-1)); end
          default: begin nb = m_y[0];   ny = W'($signed(m_y) >>> 1); end
        endcase
        m_y = ny; m_b = nb; m_s = m_s + 1'b1;
        if (m_s == '0) m_st = M_DONE;
`ifdef SHSEQ_EARLY_STOP_EN
        if (ny == '0) m_st = M_DONE;
`endif
      end
      default: m_st = M_IDLE;
    endcase
  endtask

  task automatic compare_out();
    obs_t e;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("y", y, e.y);
      check("s", s, e.s);
      check("b", b, e.b);
      check("regime", regime, e.regime);
      check("active", active, e.active);
      check("done", done, e.done);
    end
  endtask

  // Drive inputs for one edge, queue the model's expectation, compare after the edge.
  task automatic tick(input logic st, input logic [1:0] o, input logic [W-1:0] xv);
    start = st; on = o; x = xv;
    model_edge(st, o, xv);
    exp_q.push_back({m_y, m_s, m_b, m_reg, m_st == M_RUN, m_st == M_DONE});
    @(posedge clk);
    #1;
    compare_out();
  endtask

  initial begin
    logic got_done;

    tv[0] = '{2'b01, 8'h81, 8'h02, 1'b1, 8'h00, 1'b1, 3'd0, 8};
    tv[1] = '{2'b10, 8'h01, 8'h80, 1'b1, 8'h01, 1'b0, 3'd0, 8};
    tv[2] = '{2'b11, 8'h80, 8'hC0, 1'b0, 8'hFF, 1'b1, 3'd0, 8};
    tv[4] = '{2'b10, 8'hA5, 8'hD2, 1'b1, 8'hA5, 1'b1, 3'd0, 8};
`ifdef SHSEQ_EARLY_STOP_EN
    tv[3] = '{2'b01, 8'h40, 8'h80, 1'b0, 8'h00, 1'b1, 3'd2, 2};
    tv[5] = '{2'b11, 8'h5A, 8'h2D, 1'b0, 8'h00, 1'b1, 3'd7, 7};
`else
    tv[3] = '{2'b01, 8'h40, 8'h80, 1'b0, 8'h00, 1'b0, 3'd0, 8};
    tv[5] = '{2'b11, 8'h5A, 8'h2D, 1'b0, 8'h00, 1'b0, 3'd0, 8};
`endif

    // Reset values
    rst = 1'b1; start = 1'b0; on = 2'b00; x = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_y", y, 8'h00);
    check("rst_s", s, 3'd0);
    check("rst_b", b, 1'b0);
    check("rst_regime", regime, 2'b00);
    check("rst_active", active, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;

    // start with on=00 in IDLE is ignored
    repeat (3) tick(1'b1, 2'b00, 8'h33);
    check("on00_active", active, 1'b0);
    check("on00_y", y, 8'h00);

    // Table-driven runs with random (ignored) start/on during RUN and DONE
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, tv[i].mode, tv[i].x);
      check("accept_y", y, tv[i].x);
      check("accept_active", active, 1'b1);
      got_done = 1'b0;
      for (int k = 1; k <= 12 && !got_done; k++) begin
        tick(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom));
        if (k == 1) begin
          check("step1_y", y, tv[i].y1);
          check("step1_b", b, tv[i].b1);
        end
        if (done) begin
          got_done = 1'b1;
          check("end_edge", k, tv[i].end_edge);
          check("end_y", y, tv[i].y_end);
          check("end_b", b, tv[i].b_end);
          check("end_s", s, tv[i].s_end);
          check("end_regime", regime, tv[i].mode);
        end
      end
      if (!got_done) check("done_timeout", 32'd0, 32'd1);
      tick(1'b0, 2'b00, 8'h00);
      check("idle_after_done", {active, done}, 2'b00);
    end

    // start held high: next accept comes one IDLE cycle after the done pulse
    for (int k = 0; k <= 10; k++) begin
      tick(1'b1, 2'b01, 8'h81);
      if (k == 8)  check("held_done8", done, 1'b1);
      if (k == 9)  check("held_idle9", {active, done}, 2'b00);
      if (k == 10) begin
        check("held_reaccept_active", active, 1'b1);
        check("held_reaccept_y", y, 8'h81);
      end
    end

    // Asynchronous reset in the middle of a run, then no steps without start
    rst = 1'b1;
    #1;
    check("midrst_y", y, 8'h00);
    check("midrst_s", s, 3'd0);
    check("midrst_active", active, 1'b0);
    check("midrst_regime", regime, 2'b00);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) tick(1'b0, 2'b11, 8'hFF);
    check("postrst_s", s, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
